// File: rtl/morse_symbol_classifier.sv
// Morse key front end: synchronises and debounces the key, times marks and spaces
// against an (optionally adaptive) unit length and strobes dit/dah/gap/error symbols.
module morse_symbol_classifier #(
  parameter int CNT_WIDTH    = 27,
  parameter int UNIT_DEFAULT = 12500000,
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_TICKS    = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 signal,
  input  logic                 adapt,
  output logic [2:0]           symbol,
  output logic                 sym_valid,
  output logic [CNT_WIDTH-1:0] unit
);

  localparam int TW = CNT_WIDTH + 3;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] UNIT_RST = CNT_WIDTH'(UNIT_DEFAULT);
  localparam logic [DW-1:0]        DEB_LAST = DW'(DEB_TICKS - 1);

  localparam logic [2:0] SYM_NONE = 3'd0;
  localparam logic [2:0] SYM_DIT  = 3'd1;
  localparam logic [2:0] SYM_DAH  = 3'd2;
  localparam logic [2:0] SYM_LG   = 3'd3;
  localparam logic [2:0] SYM_WG   = 3'd4;
  localparam logic [2:0] SYM_ERR  = 3'd5;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, SPACE_LG} state_t;

  // Average the current unit with a dit length; never let the unit collapse to zero.
  function automatic logic [CNT_WIDTH-1:0] adapt_unit(input logic [CNT_WIDTH-1:0] u,
                                                      input logic [CNT_WIDTH-1:0] l);
    logic [CNT_WIDTH:0] sum;
    logic [CNT_WIDTH:0] half;
    sum  = {1'b0, u} + {1'b0, l};
    half = sum >> 1;
    if (half == '0) adapt_unit = CNT_WIDTH'(1);
    else            adapt_unit = half[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    sat_inc = (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Stage p0: input synchroniser
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   raw_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p0 <= '0;
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], signal};
  end

  assign raw_p0 = sync_p0[SYNC_STAGES-1];

  // Stage p1: debounced level
  logic          lvl_p1;
  logic [DW-1:0] deb_cnt_p1;
  logic          flip_p1;

  assign flip_p1 = (raw_p0 != lvl_p1) && (deb_cnt_p1 == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_p1     <= 1'b0;
      deb_cnt_p1 <= '0;
    end else if (raw_p0 == lvl_p1) begin
      deb_cnt_p1 <= '0;
    end else if (flip_p1) begin
      lvl_p1     <= raw_p0;
      deb_cnt_p1 <= '0;
    end else begin
      deb_cnt_p1 <= deb_cnt_p1 + DW'(1);
    end
  end

  // Stage p2: duration counter; len_p2 keeps the length of the level just ended
  logic [CNT_WIDTH-1:0] cnt_p2;
  logic [CNT_WIDTH-1:0] len_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p2 <= '0;
      len_p2 <= '0;
    end else if (flip_p1) begin
      cnt_p2 <= CNT_WIDTH'(1);
      len_p2 <= cnt_p2;
    end else begin
      cnt_p2 <= sat_inc(cnt_p2);
    end
  end

  logic [TW-1:0] unit_w, cnt_w, len_w, t2, t3, t6, t7;

  assign unit_w = TW'(unit);
  assign cnt_w  = TW'(cnt_p2);
  assign len_w  = TW'(len_p2);
  assign t2     = unit_w << 1;
  assign t3     = t2 + unit_w;
  assign t6     = t3 << 1;
  assign t7     = t6 + unit_w;

  state_t               state, state_n;
  logic [2:0]           sym_n;
  logic                 vld_n;
  logic [CNT_WIDTH-1:0] unit_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      symbol    <= SYM_NONE;
      sym_valid <= 1'b0;
      unit      <= UNIT_RST;
    end else begin
      state     <= state_n;
      symbol    <= sym_n;
      sym_valid <= vld_n;
      unit      <= unit_n;
    end
  end

  // A rising level always takes priority over a gap threshold in the same cycle.
  always_comb begin
    state_n = state;
    sym_n   = SYM_NONE;
    vld_n   = 1'b0;
    unit_n  = unit;
    case (state)
      IDLE: begin
        if (lvl_p1) state_n = MARK;
      end
      MARK: begin
        if (!lvl_p1) begin
          state_n = SPACE;
          vld_n   = 1'b1;
          if (len_p2 == CNT_MAX || len_w >= t6) begin
            sym_n = SYM_ERR;
          end else if (len_w >= t2) begin
            sym_n = SYM_DAH;
          end else begin
            sym_n = SYM_DIT;
            if (adapt) unit_n = adapt_unit(unit, len_p2);
          end
        end
      end
      SPACE: begin
        if (lvl_p1) begin
          state_n = MARK;
        end else if (cnt_w == t3) begin
          state_n = SPACE_LG;
          sym_n   = SYM_LG;
          vld_n   = 1'b1;
        end
      end
      SPACE_LG: begin
        if (lvl_p1) begin
          state_n = MARK;
        end else if (cnt_w == t7) begin
          state_n = IDLE;
          sym_n   = SYM_WG;
          vld_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Directed bench for morse_symbol_classifier (CNT_WIDTH=8, UNIT_DEFAULT=4,
// DEB_TICKS=2, SYNC_STAGES=2); strobes are logged with cycle stamp and unit.
module tb_morse_symbol_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signal = 1'b0;
  logic       adapt = 1'b0;
  logic [2:0] symbol;
  logic       sym_valid;
  logic [7:0] unit;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0] sym;
    int         cyc;
    logic [7:0] u;
  } ev_t;

  ev_t evq[$];

  morse_symbol_classifier #(
    .CNT_WIDTH(8),
    .UNIT_DEFAULT(4),
    .SYNC_STAGES(2),
    .DEB_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .signal(signal),
    .adapt(adapt),
    .symbol(symbol),
    .sym_valid(sym_valid),
    .unit(unit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sym_valid === 1'b1) evq.push_back('{sym: symbol, cyc: cyc, u: unit});
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    signal = 1'b0;
    adapt  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    evq.delete();
  endtask

  // Holds the key high for n cycles; tf is the cycle stamp when it drops.
  task automatic mark(input int n, output int tf);
    signal = 1'b1;
    repeat (n) @(negedge clk);
    signal = 1'b0;
    tf = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      signal = i[0];
    end
    n_checks++;
    if (symbol !== 3'd0) begin n_fail++; $display("FAIL rst_symbol: got %0d expected 0", symbol); end
    n_checks++;
    if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", sym_valid); end
    n_checks++;
    if (unit !== 8'd4) begin n_fail++; $display("FAIL rst_unit: got %0d expected 4", unit); end
    @(negedge clk);
    signal = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    signal = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", sym_valid); end
    n_checks++;
    if (unit !== 8'd4) begin n_fail++; $display("FAIL midrst_unit: got %0d expected 4", unit); end
    @(negedge clk);
    signal = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    evq.delete();
    repeat (40) @(negedge clk);
    n_checks++;
    if (evq.size() !== 0) begin n_fail++; $display("FAIL midrst_nosym: got %0d strobes expected 0", evq.size()); end
  endtask

  task automatic test_dit();
    int tf;
    do_reset();
    mark(4, tf);
    repeat (22) @(negedge clk);
    n_checks++;
    if (evq.size() !== 2) begin n_fail++; $display("FAIL dit_count: got %0d strobes expected 2", evq.size()); end
    if (evq.size() >= 2) begin
      n_checks++;
      if (evq[0].sym !== 3'd1) begin n_fail++; $display("FAIL dit_sym: got %0d expected 1", evq[0].sym); end
      n_checks++;
      if (evq[0].cyc !== tf + 5) begin n_fail++; $display("FAIL dit_time: got %0d expected %0d", evq[0].cyc, tf + 5); end
      n_checks++;
      if (evq[1].sym !== 3'd3) begin n_fail++; $display("FAIL dit_lg_sym: got %0d expected 3", evq[1].sym); end
      n_checks++;
      if (evq[1].cyc !== tf + 16) begin n_fail++; $display("FAIL dit_lg_time: got %0d expected %0d", evq[1].cyc, tf + 16); end
    end
  endtask

  task automatic test_dah_word_gap();
    int tf;
    do_reset();
    mark(12, tf);
    repeat (40) @(negedge clk);
    n_checks++;
    if (evq.size() !== 3) begin n_fail++; $display("FAIL dah_count: got %0d strobes expected 3", evq.size()); end
    if (evq.size() >= 3) begin
      n_checks++;
      if (evq[0].sym !== 3'd2) begin n_fail++; $display("FAIL dah_sym: got %0d expected 2", evq[0].sym); end
      n_checks++;
      if (evq[0].cyc !== tf + 5) begin n_fail++; $display("FAIL dah_time: got %0d expected %0d", evq[0].cyc, tf + 5); end
      n_checks++;
      if (evq[1].sym !== 3'd3 || evq[1].cyc !== tf + 16) begin
        n_fail++; $display("FAIL dah_lg: got sym %0d at %0d expected 3 at %0d", evq[1].sym, evq[1].cyc, tf + 16);
      end
      n_checks++;
      if (evq[2].sym !== 3'd4 || evq[2].cyc !== tf + 32) begin
        n_fail++; $display("FAIL dah_wg: got sym %0d at %0d expected 4 at %0d", evq[2].sym, evq[2].cyc, tf + 32);
      end
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (evq.size() !== 3) begin n_fail++; $display("FAIL idle_quiet: got %0d strobes expected 3", evq.size()); end
  endtask

  task automatic test_error();
    int tf;
    do_reset();
    mark(30, tf);
    repeat (20) @(negedge clk);
    n_checks++;
    if (evq.size() !== 2) begin n_fail++; $display("FAIL err_count: got %0d strobes expected 2", evq.size()); end
    if (evq.size() >= 2) begin
      n_checks++;
      if (evq[0].sym !== 3'd5 || evq[0].cyc !== tf + 5) begin
        n_fail++; $display("FAIL err_sym: got sym %0d at %0d expected 5 at %0d", evq[0].sym, evq[0].cyc, tf + 5);
      end
      n_checks++;
      if (evq[1].sym !== 3'd3) begin n_fail++; $display("FAIL err_lg: got %0d expected 3", evq[1].sym); end
    end
  endtask

  task automatic test_back_to_back();
    int tf1, tf2;
    do_reset();
    mark(3, tf1);
    repeat (5) @(negedge clk);
    mark(3, tf2);
    repeat (10) @(negedge clk);
    n_checks++;
    if (evq.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d strobes expected 2", evq.size()); end
    if (evq.size() >= 2) begin
      n_checks++;
      if (evq[0].sym !== 3'd1 || evq[0].cyc !== tf1 + 5) begin
        n_fail++; $display("FAIL b2b_first: got sym %0d at %0d expected 1 at %0d", evq[0].sym, evq[0].cyc, tf1 + 5);
      end
      n_checks++;
      if (evq[1].sym !== 3'd1 || evq[1].cyc !== tf2 + 5) begin
        n_fail++; $display("FAIL b2b_second: got sym %0d at %0d expected 1 at %0d", evq[1].sym, evq[1].cyc, tf2 + 5);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    signal = 1'b1;
    @(negedge clk);
    signal = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (evq.size() !== 0) begin n_fail++; $display("FAIL glitch: got %0d strobes expected 0", evq.size()); end
  endtask

  task automatic test_adapt();
    int tf;
    do_reset();
    n_checks++;
    if (unit !== 8'd4) begin n_fail++; $display("FAIL adapt_init_unit: got %0d expected 4", unit); end
    adapt = 1'b1;
    mark(6, tf);
    repeat (8) @(negedge clk);
    mark(9, tf);
    repeat (8) @(negedge clk);
    adapt = 1'b0;
    mark(6, tf);
    repeat (8) @(negedge clk);
    n_checks++;
    if (evq.size() !== 3) begin n_fail++; $display("FAIL adapt_count: got %0d strobes expected 3", evq.size()); end
    if (evq.size() >= 3) begin
      n_checks++;
      if (evq[0].sym !== 3'd1 || evq[0].u !== 8'd5) begin
        n_fail++; $display("FAIL adapt_first: got sym %0d unit %0d expected 1 unit 5", evq[0].sym, evq[0].u);
      end
      n_checks++;
      if (evq[1].sym !== 3'd1 || evq[1].u !== 8'd7) begin
        n_fail++; $display("FAIL adapt_second: got sym %0d unit %0d expected 1 unit 7", evq[1].sym, evq[1].u);
      end
      n_checks++;
      if (evq[2].sym !== 3'd1 || evq[2].u !== 8'd7) begin
        n_fail++; $display("FAIL adapt_hold: got sym %0d unit %0d expected 1 unit 7", evq[2].sym, evq[2].u);
      end
    end
    n_checks++;
    if (unit !== 8'd7) begin n_fail++; $display("FAIL adapt_final_unit: got %0d expected 7", unit); end
  endtask

  initial begin
    test_reset();
    test_dit();
    test_dah_word_gap();
    test_error();
    test_back_to_back();
    test_glitch();
    test_adapt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
